// File: rtl/ecc_encode_pipe.sv
// ecc_encode_pipe: multi-lane SECDED Hamming encoder with an elastic output
// pipeline and a one-shot error-injection facility for exercising decoders.
//
// Handshake: a beat moves across a port in every cycle where that port's
// valid and ready are both high. The producer holds valid and data steady
// until the transfer. ready_o may depend combinationally on ready_i.
module ecc_encode_pipe #(
    parameter int DataWidth = 64,
    parameter int NumLanes  = 1,
    parameter int NumStages = 1,
    parameter int CntWidth  = 32,
    localparam int LaneWidth = DataWidth / NumLanes,
    // Smallest p with 2^p >= LaneWidth + p + 1, in closed form
    localparam int ParW      = $clog2(LaneWidth + $clog2(LaneWidth + 1) + 1),
    localparam int CwWidth   = LaneWidth + ParW,
    localparam int EncWidth  = CwWidth + 1,
    localparam int LaneSelW  = (NumLanes > 1) ? $clog2(NumLanes) : 1,
    localparam int PosW      = $clog2(EncWidth)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         valid_i,
    output logic                         ready_o,
    input  logic [DataWidth-1:0]         data_i,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic [NumLanes*EncWidth-1:0] data_o,
    input  logic                         inj_arm_i,
    input  logic [1:0]                   inj_mode_i,
    input  logic [LaneSelW-1:0]          inj_lane_i,
    input  logic [PosW-1:0]              inj_pos_i,
    output logic                         inj_armed_o,
    output logic                         inj_done_o,
    output logic [CntWidth-1:0]          beat_cnt_o
);

    if ((DataWidth % NumLanes) != 0) begin : g_bad_lanes
        $error("ecc_encode_pipe: DataWidth must be a multiple of NumLanes");
    end
    if ((NumStages < 1) || (NumStages > 3)) begin : g_bad_stages
        $error("ecc_encode_pipe: NumStages must be 1..3");
    end

    // Hamming encode of one lane plus overall parity in the top bit.
    function automatic logic [EncWidth-1:0] encode_lane(input logic [LaneWidth-1:0] d);
        logic [EncWidth-1:0] enc;
        logic                par;
        int                  di;
        enc = '0;
        di  = 0;
        for (int pos = 1; pos <= CwWidth; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                enc[pos-1] = d[di];
                di++;
            end
        end
        // Parity slots are still zero here, so they do not disturb the sums
        for (int i = 0; i < ParW; i++) begin
            par = 1'b0;
            for (int pos = 1; pos <= CwWidth; pos++) begin
                if (((pos >> i) & 1) != 0) par ^= enc[pos-1];
            end
            enc[(1 << i) - 1] = par;
        end
        enc[CwWidth] = ^enc[CwWidth-1:0];
        return enc;
    endfunction

    logic [NumLanes*EncWidth-1:0] enc_word;
    logic [NumLanes*EncWidth-1:0] inj_mask;

    logic                         inj_armed_q, inj_armed_d;
    logic [1:0]                   inj_mode_q, inj_mode_d;
    logic [LaneSelW-1:0]          inj_lane_q, inj_lane_d;
    logic [PosW-1:0]              inj_pos_q, inj_pos_d;

    logic [NumStages-1:0]         valid_q, valid_d;
    logic [NumLanes*EncWidth-1:0] data_q [NumStages];
    logic [NumLanes*EncWidth-1:0] data_d [NumStages];
    logic [NumStages:0]           take;
    logic [NumStages-1:0]         in_valid;
    logic [NumLanes*EncWidth-1:0] in_data [NumStages];
    logic                         capture;

    logic [CntWidth-1:0]          beat_cnt_q, beat_cnt_d;

    // Encode every lane of the incoming word
    always_comb begin
        enc_word = '0;
        for (int k = 0; k < NumLanes; k++) begin
            enc_word[k*EncWidth +: EncWidth] = encode_lane(data_i[k*LaneWidth +: LaneWidth]);
        end
    end

    // Flip mask from the latched injection request; out-of-range pos flips nothing
    always_comb begin
        int pos_a;
        int pos_b;
        inj_mask = '0;
        pos_a = int'(inj_pos_q);
        pos_b = (pos_a + 1) % EncWidth;
        for (int k = 0; k < NumLanes; k++) begin
            for (int b = 0; b < EncWidth; b++) begin
                if ((int'(inj_lane_q) == k) && (pos_a < EncWidth)) begin
                    if ((inj_mode_q == 2'b01) && (b == pos_a)) inj_mask[k*EncWidth+b] = 1'b1;
                    if ((inj_mode_q == 2'b10) && ((b == pos_a) || (b == pos_b)))
                        inj_mask[k*EncWidth+b] = 1'b1;
                end
            end
        end
    end

    // Stage n may load when it is empty or its beat leaves this cycle
    always_comb begin
        take = '0;
        take[NumStages] = ready_i;
        for (int n = NumStages - 1; n >= 0; n--) begin
            take[n] = !valid_q[n] || take[n+1];
        end
        in_valid[0] = valid_i;
        in_data[0]  = inj_armed_q ? (enc_word ^ inj_mask) : enc_word;
        for (int n = 1; n < NumStages; n++) begin
            in_valid[n] = valid_q[n-1];
            in_data[n]  = data_q[n-1];
        end
        valid_d = valid_q;
        for (int n = 0; n < NumStages; n++) begin
            data_d[n] = data_q[n];
            if (take[n]) begin
                valid_d[n] = in_valid[n];
                if (in_valid[n]) data_d[n] = in_data[n];
            end
        end
    end

    assign ready_o = take[0];
    assign capture = valid_i && take[0];
    assign valid_o = valid_q[NumStages-1];
    assign data_o  = data_q[NumStages-1];

    // Arm/consume the one-shot injection; a new arm always wins over a capture
    always_comb begin
        inj_armed_d = inj_armed_q;
        inj_mode_d  = inj_mode_q;
        inj_lane_d  = inj_lane_q;
        inj_pos_d   = inj_pos_q;
        if (capture) inj_armed_d = 1'b0;
        if (inj_arm_i) begin
            inj_armed_d = 1'b1;
            inj_mode_d  = inj_mode_i;
            inj_lane_d  = inj_lane_i;
            inj_pos_d   = inj_pos_i;
        end
    end

    assign inj_armed_o = inj_armed_q;
    assign inj_done_o  = inj_armed_q && capture;

    // Count beats leaving the encoder; wraps naturally
    always_comb begin
        beat_cnt_d = beat_cnt_q + CntWidth'(valid_o && ready_i);
    end

    assign beat_cnt_o = beat_cnt_q;

    // State registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q     <= '0;
            for (int n = 0; n < NumStages; n++) data_q[n] <= '0;
            inj_armed_q <= 1'b0;
            inj_mode_q  <= '0;
            inj_lane_q  <= '0;
            inj_pos_q   <= '0;
            beat_cnt_q  <= '0;
        end else begin
            valid_q     <= valid_d;
            for (int n = 0; n < NumStages; n++) data_q[n] <= data_d[n];
            inj_armed_q <= inj_armed_d;
            inj_mode_q  <= inj_mode_d;
            inj_lane_q  <= inj_lane_d;
            inj_pos_q   <= inj_pos_d;
            beat_cnt_q  <= beat_cnt_d;
        end
    end

endmodule

// File: tb/tb_ecc_encode_pipe.sv
// Bench for ecc_encode_pipe: a narrow single-lane, single-stage instance (a_*)
// and a two-lane, three-stage instance (b_*), sharing clock and reset.
module tb_ecc_encode_pipe;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        a_valid_i = 1'b0, a_ready_i = 1'b1, a_inj_arm_i = 1'b0;
    logic        a_ready_o, a_valid_o, a_inj_armed_o, a_inj_done_o;
    logic [7:0]  a_data_i = '0;
    logic [12:0] a_data_o;
    logic [1:0]  a_inj_mode_i = '0;
    logic [0:0]  a_inj_lane_i = '0;
    logic [3:0]  a_inj_pos_i = '0;
    logic [3:0]  a_beat_cnt_o;

    logic        b_valid_i = 1'b0, b_ready_i = 1'b1, b_inj_arm_i = 1'b0;
    logic        b_ready_o, b_valid_o, b_inj_armed_o, b_inj_done_o;
    logic [15:0] b_data_i = '0;
    logic [25:0] b_data_o;
    logic [1:0]  b_inj_mode_i = '0;
    logic [0:0]  b_inj_lane_i = '0;
    logic [3:0]  b_inj_pos_i = '0;
    logic [31:0] b_beat_cnt_o;

    int vectors = 0;
    int miscompares = 0;
    int b_out = 0;

    ecc_encode_pipe #(.DataWidth(8), .NumLanes(1), .NumStages(1), .CntWidth(4)) dut_a (
        .clk_i(clk), .rst_i(rst), .valid_i(a_valid_i), .ready_o(a_ready_o),
        .data_i(a_data_i), .valid_o(a_valid_o), .ready_i(a_ready_i), .data_o(a_data_o),
        .inj_arm_i(a_inj_arm_i), .inj_mode_i(a_inj_mode_i), .inj_lane_i(a_inj_lane_i),
        .inj_pos_i(a_inj_pos_i), .inj_armed_o(a_inj_armed_o), .inj_done_o(a_inj_done_o),
        .beat_cnt_o(a_beat_cnt_o)
    );

    ecc_encode_pipe #(.DataWidth(16), .NumLanes(2), .NumStages(3), .CntWidth(32)) dut_b (
        .clk_i(clk), .rst_i(rst), .valid_i(b_valid_i), .ready_o(b_ready_o),
        .data_i(b_data_i), .valid_o(b_valid_o), .ready_i(b_ready_i), .data_o(b_data_o),
        .inj_arm_i(b_inj_arm_i), .inj_mode_i(b_inj_mode_i), .inj_lane_i(b_inj_lane_i),
        .inj_pos_i(b_inj_pos_i), .inj_armed_o(b_inj_armed_o), .inj_done_o(b_inj_done_o),
        .beat_cnt_o(b_beat_cnt_o)
    );

    // Reference: 8 data bits land on the non-power-of-two positions 3..12;
    // parity i is the count (mod 2) of set data bits whose position has bit i.
    function automatic logic [12:0] ref_enc8(input logic [7:0] d);
        int          dpos [8];
        int          ones;
        logic [12:0] w;
        dpos = '{3, 5, 6, 7, 9, 10, 11, 12};
        w = '0;
        for (int k = 0; k < 8; k++) if (d[k]) w[dpos[k]-1] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ones = 0;
            for (int k = 0; k < 8; k++) if (d[k] && (((dpos[k] >> i) & 1) == 1)) ones++;
            w[(1 << i) - 1] = ones[0];
        end
        w[12] = ^w[11:0];
        return w;
    endfunction

    function automatic logic [25:0] ref_b(input logic [15:0] d);
        return {ref_enc8(d[15:8]), ref_enc8(d[7:0])};
    endfunction

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        b_out = 0;
    endtask

    task automatic a_arm(input logic [1:0] mode, input logic [3:0] pos);
        @(negedge clk);
        a_inj_arm_i = 1'b1; a_inj_mode_i = mode; a_inj_pos_i = pos; a_inj_lane_i = 1'b0;
        @(negedge clk);
        a_inj_arm_i = 1'b0;
    endtask

    task automatic b_arm(input logic [1:0] mode, input logic lane, input logic [3:0] pos);
        @(negedge clk);
        b_inj_arm_i = 1'b1; b_inj_mode_i = mode; b_inj_pos_i = pos; b_inj_lane_i = lane;
        @(negedge clk);
        b_inj_arm_i = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        vectors++;
        if (a_valid_o !== 1'b0 || a_data_o !== 13'h0 || a_inj_armed_o !== 1'b0 ||
            a_inj_done_o !== 1'b0 || a_beat_cnt_o !== 4'h0) begin
            miscompares++;
            $display("FAIL reset_a: valid=%b data=%h armed=%b done=%b cnt=%0d, expected all zero",
                     a_valid_o, a_data_o, a_inj_armed_o, a_inj_done_o, a_beat_cnt_o);
        end
        vectors++;
        if (b_valid_o !== 1'b0 || b_data_o !== 26'h0 || b_beat_cnt_o !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_b: valid=%b data=%h cnt=%0d, expected all zero",
                     b_valid_o, b_data_o, b_beat_cnt_o);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++;
        if (a_ready_o !== 1'b1 || b_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready: a=%b b=%b expected 1", a_ready_o, b_ready_o);
        end
    endtask

    task automatic test_encode();
        logic [7:0]  d;
        logic [12:0] exp;
        logic [7:0]  td [3];
        logic [12:0] te [3];
        td = '{8'h01, 8'hFF, 8'h00};
        te = '{13'h1007, 13'h0F77, 13'h0000};
        for (int i = 0; i < 8; i++) begin
            if (i < 3) begin
                d = td[i]; exp = te[i];
            end else begin
                d = 8'($urandom_range(0, 255)); exp = ref_enc8(d);
            end
            @(negedge clk);
            a_valid_i = 1'b1; a_data_i = d;
            @(negedge clk);
            a_valid_i = 1'b0;
            vectors++;
            if (a_valid_o !== 1'b1 || a_data_o !== exp) begin
                miscompares++;
                $display("FAIL encode_%h: valid=%b data=%h expected 1 / %h", d, a_valid_o, a_data_o, exp);
            end
        end
    endtask

    task automatic test_inject();
        logic [7:0] d1, d2;
        // single flip at pos 0
        a_arm(2'b01, 4'd0);
        vectors++;
        if (a_inj_armed_o !== 1'b1) begin
            miscompares++; $display("FAIL inj_armed: got %b expected 1", a_inj_armed_o);
        end
        a_valid_i = 1'b1; a_data_i = 8'h01;
        #1;
        vectors++;
        if (a_inj_done_o !== 1'b1) begin
            miscompares++; $display("FAIL inj_done_single: got %b expected 1", a_inj_done_o);
        end
        @(negedge clk);
        a_valid_i = 1'b0;
        #1;
        vectors++;
        if (a_data_o !== 13'h1006 || a_inj_armed_o !== 1'b0 || a_inj_done_o !== 1'b0) begin
            miscompares++;
            $display("FAIL inj_single: data=%h armed=%b done=%b expected 1006/0/0",
                     a_data_o, a_inj_armed_o, a_inj_done_o);
        end
        @(negedge clk);
        a_valid_i = 1'b1; a_data_i = 8'h01;
        #1;
        vectors++;
        if (a_inj_done_o !== 1'b0) begin
            miscompares++; $display("FAIL inj_oneshot_done: got %b expected 0", a_inj_done_o);
        end
        @(negedge clk);
        a_valid_i = 1'b0;
        vectors++;
        if (a_data_o !== 13'h1007) begin
            miscompares++; $display("FAIL inj_oneshot: got %h expected 1007", a_data_o);
        end
        // double flip at pos 12 wraps to bit 0
        a_arm(2'b10, 4'd12);
        a_valid_i = 1'b1; a_data_i = 8'h00;
        @(negedge clk);
        a_valid_i = 1'b0;
        vectors++;
        if (a_data_o !== 13'h1001) begin
            miscompares++; $display("FAIL inj_double: got %h expected 1001", a_data_o);
        end
        // out-of-range position, then reserved mode: pulse but no flip
        for (int m = 0; m < 2; m++) begin
            if (m == 0) a_arm(2'b01, 4'd14);
            else        a_arm(2'b11, 4'd3);
            d1 = 8'($urandom_range(0, 255));
            a_valid_i = 1'b1; a_data_i = d1;
            #1;
            vectors++;
            if (a_inj_done_o !== 1'b1) begin
                miscompares++; $display("FAIL inj_noop_done_%0d: got %b expected 1", m, a_inj_done_o);
            end
            @(negedge clk);
            a_valid_i = 1'b0;
            vectors++;
            if (a_data_o !== ref_enc8(d1) || a_inj_armed_o !== 1'b0) begin
                miscompares++;
                $display("FAIL inj_noop_%0d: data=%h armed=%b expected %h/0",
                         m, a_data_o, a_inj_armed_o, ref_enc8(d1));
            end
        end
        // re-arm overwrites the latched position
        a_arm(2'b01, 4'd2);
        a_arm(2'b01, 4'd7);
        d1 = 8'($urandom_range(0, 255));
        a_valid_i = 1'b1; a_data_i = d1;
        @(negedge clk);
        a_valid_i = 1'b0;
        vectors++;
        if (a_data_o !== (ref_enc8(d1) ^ 13'h0080)) begin
            miscompares++;
            $display("FAIL inj_rearm: got %h expected %h", a_data_o, ref_enc8(d1) ^ 13'h0080);
        end
        // arm coinciding with a capture applies to the following beat
        d1 = 8'($urandom_range(0, 255));
        d2 = 8'($urandom_range(0, 255));
        @(negedge clk);
        a_inj_arm_i = 1'b1; a_inj_mode_i = 2'b01; a_inj_pos_i = 4'd4;
        a_valid_i = 1'b1; a_data_i = d1;
        #1;
        vectors++;
        if (a_inj_done_o !== 1'b0) begin
            miscompares++; $display("FAIL inj_coincide_done: got %b expected 0", a_inj_done_o);
        end
        @(negedge clk);
        a_inj_arm_i = 1'b0; a_data_i = d2;
        #1;
        vectors++;
        if (a_data_o !== ref_enc8(d1) || a_inj_armed_o !== 1'b1 || a_inj_done_o !== 1'b1) begin
            miscompares++;
            $display("FAIL inj_coincide_first: data=%h armed=%b done=%b expected %h/1/1",
                     a_data_o, a_inj_armed_o, a_inj_done_o, ref_enc8(d1));
        end
        @(negedge clk);
        a_valid_i = 1'b0;
        vectors++;
        if (a_data_o !== (ref_enc8(d2) ^ 13'h0010)) begin
            miscompares++;
            $display("FAIL inj_coincide_second: got %h expected %h", a_data_o, ref_enc8(d2) ^ 13'h0010);
        end
    endtask

    task automatic test_counter();
        pulse_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            a_valid_i = 1'b1; a_data_i = 8'($urandom_range(0, 255));
        end
        @(negedge clk);
        a_valid_i = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (a_beat_cnt_o !== 4'd10) begin
            miscompares++; $display("FAIL count_10: got %0d expected 10", a_beat_cnt_o);
        end
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            a_valid_i = 1'b1; a_data_i = 8'($urandom_range(0, 255));
        end
        @(negedge clk);
        a_valid_i = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (a_beat_cnt_o !== 4'd1) begin
            miscompares++; $display("FAIL count_wrap: got %0d expected 1", a_beat_cnt_o);
        end
    endtask

    task automatic test_lanes();
        logic [25:0] exp;
        for (int t = 0; t < 2; t++) begin
            if (t == 1) b_arm(2'b01, 1'b1, 4'd5);
            b_ready_i = 1'b1;
            @(negedge clk);
            b_valid_i = 1'b1; b_data_i = 16'hFF01;
            @(negedge clk);
            b_valid_i = 1'b0;
            for (int c = 1; c < 3; c++) begin
                vectors++;
                if (b_valid_o !== 1'b0) begin
                    miscompares++; $display("FAIL lanes_early_%0d_%0d: valid=%b expected 0", t, c, b_valid_o);
                end
                @(negedge clk);
            end
            exp = (t == 0) ? {13'h0F77, 13'h1007} : {13'h0F77 ^ 13'h0020, 13'h1007};
            vectors++;
            if (b_valid_o !== 1'b1 || b_data_o !== exp) begin
                miscompares++;
                $display("FAIL lanes_%0d: valid=%b data=%h expected 1 / %h", t, b_valid_o, b_data_o, exp);
            end
            b_out++;
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [25:0] exp_q [$];
        logic [25:0] exp;
        logic [25:0] held;
        bit          hold_prev;
        bit          acc;
        int          sent;
        int          got;
        int          cycles;
        sent = 0; got = 0; cycles = 0; hold_prev = 1'b0; acc = 1'b0; held = '0;
        b_valid_i = 1'b0;
        while ((sent < 1000 || exp_q.size() > 0) && cycles < 20000) begin
            @(negedge clk);
            cycles++;
            if (hold_prev) begin
                vectors++;
                if (b_valid_o !== 1'b1 || b_data_o !== held) begin
                    miscompares++;
                    $display("FAIL stall_hold: valid=%b data=%h expected 1 / %h", b_valid_o, b_data_o, held);
                end
            end
            if (!b_valid_i || acc) begin
                if (sent < 1000 && $urandom_range(0, 3) != 0) begin
                    b_valid_i = 1'b1; b_data_i = 16'($urandom_range(0, 65535));
                end else begin
                    b_valid_i = 1'b0;
                end
            end
            b_ready_i = ($urandom_range(0, 3) != 0);
            #1;
            acc = b_valid_i && b_ready_o;
            if (acc) begin
                exp_q.push_back(ref_b(b_data_i));
                sent++;
            end
            if (b_valid_o && b_ready_i) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL stream_extra: got %h expected no beat", b_data_o);
                end else begin
                    exp = exp_q.pop_front();
                    if (b_data_o !== exp) begin
                        miscompares++;
                        $display("FAIL stream_beat_%0d: got %h expected %h", got, b_data_o, exp);
                    end
                end
                got++;
                b_out++;
            end
            hold_prev = b_valid_o && !b_ready_i;
            held = b_data_o;
        end
        b_valid_i = 1'b0;
        b_ready_i = 1'b1;
        vectors++;
        if (got !== 1000 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL stream_total: got %0d beats (%0d pending, %0d cycles) expected 1000",
                     got, exp_q.size(), cycles);
        end
        @(negedge clk);
        vectors++;
        if (b_beat_cnt_o !== 32'(b_out)) begin
            miscompares++; $display("FAIL stream_count: got %0d expected %0d", b_beat_cnt_o, b_out);
        end
    endtask

    task automatic test_reset_midstream();
        logic [15:0] d;
        b_ready_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            b_valid_i = 1'b1; b_data_i = 16'($urandom_range(0, 65535));
        end
        @(negedge clk);
        b_valid_i = 1'b0;
        b_arm(2'b01, 1'b0, 4'd2);
        vectors++;
        if (b_valid_o !== 1'b1 || b_inj_armed_o !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_pre: valid=%b armed=%b expected 1/1", b_valid_o, b_inj_armed_o);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (b_valid_o !== 1'b0 || b_inj_armed_o !== 1'b0 || b_data_o !== 26'h0) begin
            miscompares++;
            $display("FAIL midreset: valid=%b armed=%b data=%h expected 0/0/0",
                     b_valid_o, b_inj_armed_o, b_data_o);
        end
        @(negedge clk);
        rst = 1'b0;
        b_out = 0;
        b_ready_i = 1'b1;
        d = 16'($urandom_range(0, 65535));
        @(negedge clk);
        b_valid_i = 1'b1; b_data_i = d;
        #1;
        vectors++;
        if (b_ready_o !== 1'b1 || b_inj_done_o !== 1'b0) begin
            miscompares++;
            $display("FAIL postreset_accept: ready=%b done=%b expected 1/0", b_ready_o, b_inj_done_o);
        end
        @(negedge clk);
        b_valid_i = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (b_valid_o !== 1'b1 || b_data_o !== ref_b(d)) begin
            miscompares++;
            $display("FAIL postreset_clean: valid=%b data=%h expected 1 / %h", b_valid_o, b_data_o, ref_b(d));
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_encode();
        test_inject();
        test_counter();
        test_lanes();
        test_back_to_back();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ecc_encode_pipe.md
Name: ecc_encode_pipe

Overview:
Pipelined, multi-lane SECDED Hamming encoder (extended parity) with valid/ready handshake. A wide data word is split into NumLanes independent lanes, each encoded separately, then registered through NumStages elastic stages. A one-shot error-injection facility corrupts a chosen encoded beat, so downstream decoders and scrubbers can be verified in-system. Sits between a memory or interconnect write path and ECC-protected storage.

Parameters:
DataWidth, 64, total unencoded width; must be divisible by NumLanes.
NumLanes, 1, number of independently encoded lanes; LaneWidth = DataWidth/NumLanes.
NumStages, 1, number of pipeline register stages; legal range 1..3.
CntWidth, 32, width of the encoded-beat counter.
Derived: P = smallest p with 2^p >= LaneWidth+p+1; CwWidth = LaneWidth+P; EncWidth = CwWidth+1.

Ports:
clk_i  in  1  clock.
rst_i  in  1  asynchronous, active-high reset.
valid_i  in  1  input beat valid.
ready_o  out  1  encoder can accept a beat.
data_i  in  DataWidth  unencoded data; lane k = data_i[k*LaneWidth +: LaneWidth].
valid_o  out  1  encoded beat valid.
ready_i  in  1  downstream accepts beat.
data_o  out  NumLanes*EncWidth  encoded data; lane k = data_o[k*EncWidth +: EncWidth].
inj_arm_i  in  1  pulse: arm one-shot injection.
inj_mode_i  in  2  00 none, 01 single-bit flip, 10 double-bit flip, 11 reserved (treated as 00).
inj_lane_i  in  max(1,$clog2(NumLanes))  target lane.
inj_pos_i  in  $clog2(EncWidth)  target bit index in lane's encoded word.
inj_armed_o  out  1  injection pending.
inj_done_o  out  1  one-cycle pulse when injection applied.
beat_cnt_o  out  CntWidth  count of beats accepted at output.

Behaviour:
- Encoding per lane, combinational ahead of stage 1: codeword positions 1..CwWidth; power-of-two positions hold parity; data bits fill remaining positions LSB first, in ascending position order. Parity bit i = XOR of all positions whose index has bit i set. Encoded word bit (pos-1) = codeword position pos. Bit CwWidth = XOR of the full codeword.
- Pipeline: NumStages valid/ready registers. Stage n loads when empty or when its content is consumed in the same cycle. ready_o = stage-1 empty OR stage-1 advancing; combinational from ready_i permitted. Full throughput of 1 beat/cycle. Latency from input handshake to valid_o = NumStages cycles. No beat is dropped or duplicated under any ready_i pattern. Held data_o/valid_o stay stable while valid_o && !ready_i.
- Injection: inj_arm_i sets armed and latches mode/lane/pos; re-arming while armed overwrites the latched values. The next beat captured into stage 1 while armed with mode 01 flips bit pos of the target lane. Mode 10 flips bits pos and (pos+1) mod EncWidth. inj_done_o pulses in the capture cycle and armed clears. Mode 00/11 with arming: armed clears on next capture, inj_done_o still pulses, no flip. If inj_arm_i coincides with a capture while not armed, the injection applies to the following beat. inj_pos_i >= EncWidth: no flip.
- beat_cnt_o increments on each valid_o && ready_i and wraps to 0 at 2^CntWidth.
- Reset values: all stage valids 0, valid_o 0, data_o 0, inj_armed_o 0, inj_done_o 0, beat_cnt_o 0. ready_o = 1 after reset. Reset mid-stream discards in-flight beats and pending injection.
- Elaboration error if DataWidth mod NumLanes != 0 or NumStages is outside 1..3.

Test Plan:
- DataWidth=8, NumLanes=1, NumStages=1: data 0x01 -> data_o 0x1007 one cycle later; 0xFF -> 0x0F77; 0x00 -> 0x0000.
- Arm mode 01, pos 0, then send 0x01 -> 0x1006 with inj_done_o pulse; next beat 0x01 -> 0x1007, inj_armed_o = 0.
- Arm mode 10, pos 12, send 0x00 -> bits 12 and 0 flipped -> 0x1001.
- DataWidth=16, NumLanes=2, NumStages=3: data 0xFF01 -> {0x0F77, 0x1007}, valid_o 3 cycles after accept; random ready_i backpressure over 1000 beats -> in-order, lossless, each beat matches reference model.
- Stream 10 beats with ready_i=1 -> beat_cnt_o = 10. With CntWidth=4, 17 beats -> beat_cnt_o = 1.
- Assert rst_i with 2 beats in flight and injection armed -> valid_o = 0, inj_armed_o = 0 immediately; first beat after release encodes cleanly.
